// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array output collector.
// Holds the element/row geometry, the row type carried through the FIFO,
// the beat FSM state type and the optional ReLU helper.
package systolic_pkg;

   localparam int WIDTH    = 16;               // element width, two's complement
   localparam int FRAC_BIT = 10;               // fractional bits of the Q format
   localparam int N        = 6;                // elements per row (even)
   localparam int BEATS    = N / 2;            // AXIS beats per row
   localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int AXIS_W   = 2 * WIDTH;        // two elements per beat

   // Element i of a row lives at bits [i*WIDTH +: WIDTH].
   typedef logic [N*WIDTH-1:0] row_t;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   // Clamp negative elements to zero; the Q format is irrelevant for a sign test.
   function automatic logic [WIDTH-1:0] relu(input logic [WIDTH-1:0] elem);
      return elem[WIDTH-1] ? '0 : elem;
   endfunction

endpackage

// File: rtl/systolic_collector_if.sv
// AXI4-Stream link carrying serialised result rows toward the DMA.
// master: collector side; slave: DMA or testbench side.
interface systolic_collector_if;
   import systolic_pkg::*;

   logic [AXIS_W-1:0] tdata;
   logic              tvalid;
   logic              tready;
   logic              tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/systolic_row_fifo.sv
// Synchronous row FIFO between the array capture point and the output row register.
// Push and pop in the same cycle are allowed even when full; flush empties it in one edge.
module systolic_row_fifo
   import systolic_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   push,
   input  row_t                   wdata,
   input  logic                   pop,
   output row_t                   rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   row_t             mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Row storage write port.
   // NOTE: the storage array has no reset; pointers and count alone define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   // Pointer and occupancy tracking; flush discards all rows at once.
   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign rdata = mem[rd_ptr];
   assign full  = (count == (PTR_W+1)'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/systolic_collector.sv
// Output stage of the 6x6 systolic MAC array: captures result rows, buffers them in a
// row FIFO, and serialises each row as N/2 32-bit AXI4-Stream beats with tlast closing
// every frame of row_count rows.
// Optional macro RELU_EN: clamp negative elements to zero at capture.
module systolic_collector
   import systolic_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        en,
   input  logic                        clr,
   input  logic [WIDTH-1:0]            y0,
   input  logic [WIDTH-1:0]            y1,
   input  logic [WIDTH-1:0]            y2,
   input  logic [WIDTH-1:0]            y3,
   input  logic [WIDTH-1:0]            y4,
   input  logic [WIDTH-1:0]            y5,
   input  logic                        y_valid,
   input  logic [7:0]                  row_count,
   systolic_collector_if.master        m_axis,
   output logic                        overflow,
   output logic                        busy
);

   row_t                   row_in;
   row_t                   fifo_rdata;
   row_t                   orr;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [$clog2(DEPTH):0] fifo_count;
   logic                   push;
   logic                   drop;
   logic                   load;

   state_t                 state, state_next;
   logic [BEAT_W-1:0]      beat, beat_next;
   logic [7:0]             row_cnt, row_cnt_next;
   logic [7:0]             frame_len, frame_len_next;

   logic                   hs;
   logic                   last_beat;
   logic                   frame_end;

   // Assemble the incoming row, optionally clamping negatives before it is buffered.
   always_comb begin
      row_in = {y5, y4, y3, y2, y1, y0};
`ifdef RELU_EN
      for (int i = 0; i < N; i++) begin
         row_in[i*WIDTH +: WIDTH] = relu(row_in[i*WIDTH +: WIDTH]);
      end
`endif
   end

   // A row is accepted when there is room now or the head leaves in the same cycle.
   assign push = y_valid && en && !clr && (!fifo_full || load);
   assign drop = y_valid && en && !clr &&   fifo_full && !load;

   systolic_row_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (clr),
      .push  (push),
      .wdata (row_in),
      .pop   (load),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign m_axis.tvalid = (state == SEND);
   assign hs            = m_axis.tvalid && m_axis.tready;
   assign last_beat     = (beat == BEAT_W'(BEATS - 1));
   assign frame_end     = last_beat && (row_cnt == frame_len - 8'd1);
   assign m_axis.tlast  = m_axis.tvalid && frame_end;
   assign busy          = (fifo_count != '0) || (state == SEND);

   // Beat FSM next state: advance on handshake, reload the ORR without a bubble.
   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_next     = state;
      beat_next      = beat;
      row_cnt_next   = row_cnt;
      frame_len_next = frame_len;
      load           = 1'b0;

      if (hs) begin
         if (last_beat) begin
            beat_next    = '0;
            row_cnt_next = frame_end ? 8'd0 : row_cnt + 8'd1;
         end else begin
            beat_next = beat + 1'b1;
         end
      end

      if ((state == IDLE) || (hs && last_beat)) begin
         if (!fifo_empty) begin
            load       = 1'b1;
            state_next = SEND;
            // Frame length is latched only when the first row of a frame loads.
            if (row_cnt_next == 8'd0) frame_len_next = (row_count == 8'd0) ? 8'd1 : row_count;
         end else begin
            state_next = IDLE;
         end
      end

      if (clr) begin
         state_next     = IDLE;
         beat_next      = '0;
         row_cnt_next   = '0;
         frame_len_next = frame_len;
         load           = 1'b0;
      end
   end

   // Beat FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Beat, frame counters and output row register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat      <= '0;
         row_cnt   <= '0;
         frame_len <= '0;
         orr       <= '0;
      end else begin
         beat      <= beat_next;
         row_cnt   <= row_cnt_next;
         frame_len <= frame_len_next;
         if (clr)       orr <= '0;
         else if (load) orr <= fifo_rdata;
      end
   end

   // Sticky overflow: set by a dropped row, cleared only by clr or reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    overflow <= 1'b0;
      else if (clr)  overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
   end

   // Select the current beat's element pair from the output row register.
   always_comb begin
      m_axis.tdata = '0;
      for (int k = 0; k < BEATS; k++) begin
         if (beat == BEAT_W'(k)) m_axis.tdata = orr[k*AXIS_W +: AXIS_W];
      end
   end

endmodule

// File: tb/tb_systolic_collector.sv
// Self-checking bench for systolic_collector: directed scenarios followed by random
// traffic, compared against a row-queue reference model kept in the bench.
module tb_systolic_collector;
   import systolic_pkg::*;

   localparam int TB_DEPTH = 8;

   typedef struct {
      logic [31:0] data;
      logic        last;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        clr;
   logic        y_valid;
   logic [15:0] y [6];
   logic [7:0]  row_count;
   logic        overflow;
   logic        busy;

   systolic_collector_if m_axis ();

   systolic_collector #(.DEPTH(TB_DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .clr       (clr),
      .y0        (y[0]),
      .y1        (y[1]),
      .y2        (y[2]),
      .y3        (y[3]),
      .y4        (y[4]),
      .y5        (y[5]),
      .y_valid   (y_valid),
      .row_count (row_count),
      .m_axis    (m_axis),
      .overflow  (overflow),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Reference model state
   beat_t exp_q [$];
   beat_t seen  [$];
   int    held;
   int    bpos;
   int    fpos;
   int    flen;
   bit    m_tvalid;
   bit    m_ovf;

   int    total;
   int    bad;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Append the beats of an accepted row, with frame position decided by row order.
   task automatic add_row();
      logic [15:0] e [6];
      bit          row_last;
      beat_t       b;
      for (int i = 0; i < 6; i++) begin
`ifdef RELU_EN
         e[i] = y[i][15] ? 16'h0000 : y[i];
`else
         e[i] = y[i];
`endif
      end
      if (fpos == 0) flen = (row_count == 0) ? 1 : int'(row_count);
      row_last = (fpos == flen - 1);
      for (int k = 0; k < 3; k++) begin
         b.data = {e[2*k+1], e[2*k]};
         b.last = row_last && (k == 2);
         exp_q.push_back(b);
      end
      fpos = row_last ? 0 : fpos + 1;
   endtask

   task automatic check_outputs();
      check("tvalid", {31'd0, m_axis.tvalid}, {31'd0, m_tvalid});
      check("busy", {31'd0, busy}, {31'd0, held > 0});
      check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
      if (m_tvalid && exp_q.size() > 0) begin
         check("tdata", m_axis.tdata, exp_q[0].data);
         check("tlast", {31'd0, m_axis.tlast}, {31'd0, exp_q[0].last});
      end else begin
         check("tlast_idle", {31'd0, m_axis.tlast}, 32'd0);
      end
   endtask

   // One clock: predict the effect of the driven inputs, clock the DUT, compare.
   task automatic tick();
      bit    hs;
      int    just;
      beat_t b;
      just = 0;
      hs   = m_tvalid && (m_axis.tready === 1'b1);
      if (clr) begin
         exp_q.delete();
         held  = 0;
         bpos  = 0;
         fpos  = 0;
         m_ovf = 1'b0;
      end else begin
         if (hs) begin
            b.data = m_axis.tdata;
            b.last = m_axis.tlast;
            seen.push_back(b);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            bpos++;
            if (bpos == 3) begin
               bpos = 0;
               held--;
            end
         end
         if (y_valid && en) begin
            if (held < TB_DEPTH + 1) begin
               add_row();
               held++;
               just = 1;
            end else begin
               m_ovf = 1'b1;
            end
         end
      end
      m_tvalid = (held - just) > 0;
      @(posedge clk);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic rand_row();
      for (int i = 0; i < 6; i++) y[i] = 16'($urandom);
   endtask

   task automatic drain();
      int n;
      n = 0;
      y_valid       = 1'b0;
      clr           = 1'b0;
      m_axis.tready = 1'b1;
      while (busy !== 1'b0 && n < 200) begin
         tick();
         n++;
      end
      check("drain_busy", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int nlast;
      total = 0;
      bad   = 0;
      held  = 0;
      bpos  = 0;
      fpos  = 0;
      flen  = 1;
      m_tvalid = 1'b0;
      m_ovf    = 1'b0;

      // Reset
      rst_n         = 1'b0;
      en            = 1'b1;
      clr           = 1'b0;
      y_valid       = 1'b0;
      row_count     = 8'd1;
      m_axis.tready = 1'b0;
      for (int i = 0; i < 6; i++) y[i] = '0;
      repeat (2) @(negedge clk);
      check("rst_tvalid", {31'd0, m_axis.tvalid}, 32'd0);
      check("rst_tlast", {31'd0, m_axis.tlast}, 32'd0);
      check("rst_tdata", m_axis.tdata, 32'd0);
      check("rst_overflow", {31'd0, overflow}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      tick();

      // Single row, known values
      seen.delete();
      row_count     = 8'd1;
      m_axis.tready = 1'b1;
      y[0] = 16'h0400; y[1] = 16'hFC00; y[2] = 16'h0800;
      y[3] = 16'h0C00; y[4] = 16'hF800; y[5] = 16'h1000;
      y_valid = 1'b1;
      tick();
      y_valid = 1'b0;
      drain();
      check("t1_beats", seen.size(), 32'd3);
      if (seen.size() == 3) begin
`ifdef RELU_EN
         check("t1_beat0", seen[0].data, 32'h00000400);
         check("t1_beat1", seen[1].data, 32'h0C000800);
         check("t1_beat2", seen[2].data, 32'h10000000);
`else
         check("t1_beat0", seen[0].data, 32'hFC000400);
         check("t1_beat1", seen[1].data, 32'h0C000800);
         check("t1_beat2", seen[2].data, 32'h1000F800);
`endif
         check("t1_last0", {31'd0, seen[0].last}, 32'd0);
         check("t1_last2", {31'd0, seen[2].last}, 32'd1);
      end

      // Backpressure mid-row
      seen.delete();
      rand_row();
      y_valid = 1'b1;
      tick();
      y_valid = 1'b0;
      tick();
      tick();
      m_axis.tready = 1'b0;
      repeat (5) tick();
      drain();
      check("t2_beats", seen.size(), 32'd3);

      // Frame of five rows
      seen.delete();
      row_count = 8'd5;
      for (int r = 0; r < 5; r++) begin
         rand_row();
         y_valid = 1'b1;
         tick();
         y_valid = 1'b0;
         tick();
      end
      drain();
      check("t3_beats", seen.size(), 32'd15);
      nlast = 0;
      foreach (seen[i]) if (seen[i].last) nlast++;
      check("t3_nlast", nlast, 32'd1);
      if (seen.size() == 15) check("t3_last14", {31'd0, seen[14].last}, 32'd1);
      rand_row();
      y_valid = 1'b1;
      tick();
      drain();
      if (seen.size() > 15) check("t3_next_first", {31'd0, seen[15].last}, 32'd0);

      // Overflow with a stalled sink
      clr = 1'b1;
      tick();
      clr = 1'b0;
      seen.delete();
      row_count     = 8'd3;
      m_axis.tready = 1'b0;
      for (int r = 0; r < 10; r++) begin
         rand_row();
         y_valid = 1'b1;
         tick();
      end
      y_valid = 1'b0;
      check("t4_overflow", {31'd0, overflow}, 32'd1);
      drain();
      check("t4_beats", seen.size(), 32'd27);
      check("t4_ovf_sticky", {31'd0, overflow}, 32'd1);

      // clr with rows buffered
      m_axis.tready = 1'b0;
      for (int r = 0; r < 3; r++) begin
         rand_row();
         y_valid = 1'b1;
         tick();
      end
      y_valid = 1'b1;
      clr     = 1'b1;
      tick();
      clr     = 1'b0;
      y_valid = 1'b0;
      check("t5_tvalid", {31'd0, m_axis.tvalid}, 32'd0);
      check("t5_busy", {31'd0, busy}, 32'd0);
      check("t5_overflow", {31'd0, overflow}, 32'd0);
      seen.delete();
      row_count = 8'd2;
      rand_row();
      y_valid = 1'b1;
      tick();
      drain();
      check("t5_beats", seen.size(), 32'd3);
      if (seen.size() == 3) check("t5_restart_last", {31'd0, seen[2].last}, 32'd0);
      clr = 1'b1;
      tick();
      clr = 1'b0;

      // Capture disabled
      en = 1'b0;
      m_axis.tready = 1'b1;
      for (int r = 0; r < 5; r++) begin
         rand_row();
         y_valid = r[0];
         tick();
      end
      y_valid = 1'b0;
      tick();
      check("t6_tvalid", {31'd0, m_axis.tvalid}, 32'd0);
      check("t6_overflow", {31'd0, overflow}, 32'd0);
      en = 1'b1;

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         rand_row();
         if (held == 0 && $urandom_range(0, 9) == 0) row_count = 8'($urandom_range(0, 4));
         y_valid       = ($urandom_range(0, 99) < 45);
         en            = ($urandom_range(0, 99) < 90);
         m_axis.tready = ($urandom_range(0, 99) < 55);
         clr           = ($urandom_range(0, 299) == 0);
         tick();
      end
      en = 1'b1;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
